// File: rtl/dpram_arb_pkg.sv
// dpram_arb_pkg -- shared types and defaults for the dual-port RAM arbiter.
//   arb_state_t     : arbiter FSM state encoding (IDLE, ACCESS, DONE)
//   NUM_REQ_DEFAULT : default number of requesters
//   ADDR_W_DEFAULT  : default RAM address width
//   DATA_W_DEFAULT  : default RAM data width
package dpram_arb_pkg;

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int ADDR_W_DEFAULT  = 8;
  localparam int DATA_W_DEFAULT  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dpram_arbiter_if.sv
// dpram_arbiter_if -- requester-side bus of the dual-port RAM arbiter.
//   req   : per-requester access request (level)
//   we    : per-requester write enable, meaningful only while req is high
//   addr  : packed per-requester addresses, slice i belongs to requester i
//   wdata : packed per-requester write data, slice i belongs to requester i
//   ack   : one-cycle completion pulse per requester
//   rdata : read data, valid in the cycle ack is high
//
// Handshake: a requester raises req[i] together with we/addr/wdata and keeps
// all of them stable up to and including the cycle ack[i] is high. ack[i] is
// the only completion indication; in the following cycle the requester
// either drops req[i] or presents a new request. There is no backpressure
// other than waiting for ack.
interface dpram_arbiter_if
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_DEFAULT,
  parameter int widthad_a = ADDR_W_DEFAULT,
  parameter int width_a   = DATA_W_DEFAULT
);

  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ-1:0]           we;
  logic [NUM_REQ*widthad_a-1:0] addr;
  logic [NUM_REQ*width_a-1:0]   wdata;
  logic [NUM_REQ-1:0]           ack;
  logic [width_a-1:0]           rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/dpram_arbiter_rr_pick.sv
// rr_pick -- combinational round-robin winner search.
//   req        : request vector
//   last_grant : index granted most recently
//   valid      : at least one request bit set
//   index      : first set request found starting at last_grant+1 (wrapping)
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    valid    = 1'b0;
    index    = '0;
    cand     = 0;
    cand_idx = '0;
    // Offsets 1..NUM_REQ visit every requester once; the previous winner
    // comes last so it cannot starve anyone.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand     = (int'(last_grant) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        index = cand_idx;
      end
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// dpram_arbiter -- round-robin arbiter sharing port A of a dual-port RAM
// between NUM_REQ requesters. Each access takes a fixed three cycles:
// IDLE (grant) -> ACCESS (RAM signals presented) -> DONE (ack + rdata).
//   clock, reset_n : clock and synchronous active-low reset
//   bus            : requester bus (req/we/addr/wdata in, ack/rdata out)
//   busy           : high whenever the FSM is not in IDLE
//   grant_id       : index of the requester being served
//   ram_address    : RAM port A address
//   ram_data       : RAM port A write data
//   ram_wren       : RAM port A write enable
//   ram_q          : RAM port A registered read data (read-before-write)
//   dbg_state      : current FSM state
module dpram_arbiter
  import dpram_arb_pkg::*;
#(
  parameter  int NUM_REQ   = NUM_REQ_DEFAULT,
  parameter  int widthad_a = ADDR_W_DEFAULT,
  parameter  int width_a   = DATA_W_DEFAULT,
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  dpram_arbiter_if.slave       bus,
  output logic                 busy,
  output logic [IDX_W-1:0]     grant_id,
  output logic [widthad_a-1:0] ram_address,
  output logic [width_a-1:0]   ram_data,
  output logic                 ram_wren,
  input  logic [width_a-1:0]   ram_q,
  output arb_state_t           dbg_state
);

  arb_state_t           state_q;
  arb_state_t           state_d;
  logic [IDX_W-1:0]     last_grant_q;
  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [width_a-1:0]   rdata_q;
  logic                 grant_now;

  logic [widthad_a-1:0] addr_arr  [NUM_REQ];
  logic [width_a-1:0]   wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = bus.addr[gi*widthad_a +: widthad_a];
    assign wdata_arr[gi] = bus.wdata[gi*width_a +: width_a];
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req        (bus.req),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .index      (pick_idx)
  );

  // Requests are only looked at in IDLE; anything raised during ACCESS or
  // DONE waits for the next IDLE cycle.
  assign grant_now = (state_q == IDLE) && pick_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = ACCESS;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Once granted, the access runs to completion regardless of req; only
  // reset can stop it. A reset during ACCESS still lets the RAM take the
  // write presented in that cycle, since ram_wren is low only after the edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      grant_id     <= '0;
      ram_address  <= '0;
      ram_data     <= '0;
      ram_wren     <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q <= state_d;
      if (grant_now) begin
        grant_id     <= pick_idx;
        last_grant_q <= pick_idx;
        ram_address  <= addr_arr[pick_idx];
        ram_data     <= wdata_arr[pick_idx];
        ram_wren     <= bus.we[pick_idx];
      end else begin
        ram_wren <= 1'b0;
      end
      if (state_q == DONE) begin
        rdata_q <= ram_q;
      end
    end
  end

  // rdata follows ram_q during the ack cycle and holds it afterwards.
  always_comb begin
    bus.ack = '0;
    if (state_q == DONE) begin
      bus.ack[grant_id] = 1'b1;
    end
  end

  assign bus.rdata = (state_q == DONE) ? ram_q : rdata_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dpram_arbiter.sv
// tb_dpram_arbiter -- self-checking bench for dpram_arbiter driving a
// behavioural dual-port RAM port A (8-bit address, 8-bit data).
module tb_dpram_arbiter;
  import dpram_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT and RAM ----------------
  dpram_arbiter_if #(.NUM_REQ(N), .widthad_a(AW), .width_a(DW)) bus ();

  logic          busy;
  logic [IW-1:0] grant_id;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic [DW-1:0] ram_q;
  arb_state_t    dbg_state;

  dpram_arbiter #(.NUM_REQ(N), .widthad_a(AW), .width_a(DW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .busy        (busy),
    .grant_id    (grant_id),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_q       (ram_q),
    .dbg_state   (dbg_state)
  );

  logic [DW-1:0] mem [256] = '{default: '0};
  always @(posedge clock) begin
    ram_q <= mem[ram_address];
    if (ram_wren) mem[ram_address] <= ram_data;
  end

  // ---------------- requester drive state ----------------
  logic          p_req   [N];
  logic          p_we    [N];
  logic [AW-1:0] p_addr  [N];
  logic [DW-1:0] p_wdata [N];
  logic          p_hold  [N];
  int            p_wait  [N];

  logic [N-1:0]    req_v, we_v;
  logic [N*AW-1:0] addr_v;
  logic [N*DW-1:0] wdata_v;
  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_v[gi]              = p_req[gi];
    assign we_v[gi]               = p_we[gi];
    assign addr_v[gi*AW +: AW]    = p_addr[gi];
    assign wdata_v[gi*DW +: DW]   = p_wdata[gi];
  end
  assign bus.req   = req_v;
  assign bus.we    = we_v;
  assign bus.addr  = addr_v;
  assign bus.wdata = wdata_v;

  // ---------------- reference model ----------------
  // g counts clock edges since the most recent grant (2 = idle again).
  logic [DW-1:0] exp_mem [256] = '{default: '0};
  int            g;
  int            last_g;
  logic          w_we;
  logic [DW-1:0] w_rd;
  logic [N-1:0]  e_ack;
  logic          e_busy, e_wren;
  logic [DW-1:0] e_rdata;
  logic [IW-1:0] e_grant;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  int            acked;
  int            ack_wait;

  int tests = 0;
  int fails = 0;

  task automatic post(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_req[i]   = 1'b1;
    p_we[i]    = w;
    p_addr[i]  = a;
    p_wdata[i] = d;
    p_wait[i]  = 0;
  endtask

  // Advance one clock; the model decides what the coming edge does from the
  // currently driven requests, then expected outputs are set for the new cycle.
  task automatic tick();
    int pick;
    pick = -1;
    if (!reset_n) begin
      g = 2; last_g = N - 1;
      e_rdata = '0; e_grant = '0; e_addr = '0; e_data = '0; w_we = 1'b0;
    end else if (g < 2) begin
      g++;
    end else begin
      for (int k = 1; k <= N; k++)
        if (pick < 0 && p_req[(last_g + k) % N]) pick = (last_g + k) % N;
      if (pick >= 0) begin
        g       = 0;
        last_g  = pick;
        e_grant = IW'(pick);
        w_we    = p_we[pick];
        e_addr  = p_addr[pick];
        e_data  = p_wdata[pick];
        w_rd    = exp_mem[e_addr];
        if (w_we) exp_mem[e_addr] = e_data;
      end
    end
    @(negedge clock);
    for (int i = 0; i < N; i++) if (p_req[i]) p_wait[i]++;
    e_busy = (g < 2);
    e_wren = (g == 0) && w_we;
    e_ack  = '0;
    acked  = -1;
    if (g == 1) begin
      acked    = last_g;
      e_ack    = N'(1) << last_g;
      e_rdata  = w_rd;
      ack_wait = p_wait[last_g];
      p_wait[last_g] = 0;
      if (!p_hold[last_g]) p_req[last_g] = 1'b0;
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      p_req[i] = 1'b0; p_hold[i] = 1'b0; p_wait[i] = 0;
    end
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_ack(input int i, input int budget, output int n);
    n = -1;
    for (int t = 1; t <= budget; t++) begin
      tick();
      if (bus.ack[i] === 1'b1) begin
        n = t;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    tests++;
    if (bus.ack !== '0 || busy !== 1'b0 || ram_wren !== 1'b0 || dbg_state !== IDLE) begin
      fails++;
      $display("FAIL reset_ctl: ack=%b busy=%b wren=%b state=%0d, want 0 0 0 %0d",
               bus.ack, busy, ram_wren, dbg_state, IDLE);
    end
    tests++;
    if (ram_address !== '0 || ram_data !== '0 || bus.rdata !== '0 || grant_id !== '0) begin
      fails++;
      $display("FAIL reset_data: addr=%h data=%h rdata=%h grant=%0d, want all 0",
               ram_address, ram_data, bus.rdata, grant_id);
    end
  endtask

  task automatic test_write_read();
    int n;
    do_reset();
    post(0, 1'b1, 8'h10, 8'h5A);
    tick();
    tests++;
    if (ram_wren !== 1'b1 || ram_address !== 8'h10 || ram_data !== 8'h5A || bus.ack !== '0) begin
      fails++;
      $display("FAIL wr_access: wren=%b addr=%h data=%h ack=%b, want 1 10 5a 0000",
               ram_wren, ram_address, ram_data, bus.ack);
    end
    tick();
    tests++;
    if (bus.ack !== 4'b0001 || ram_wren !== 1'b0) begin
      fails++;
      $display("FAIL wr_ack: ack=%b wren=%b, want 0001 0", bus.ack, ram_wren);
    end
    tick();
    post(0, 1'b0, 8'h10, 8'h00);
    wait_ack(0, 10, n);
    tests++;
    if (n !== 2 || bus.rdata !== 8'h5A) begin
      fails++;
      $display("FAIL rd_back: latency=%0d rdata=%h, want 2 5a", n, bus.rdata);
    end
    tick();
    tests++;
    if (bus.rdata !== 8'h5A || bus.ack !== '0) begin
      fails++;
      $display("FAIL rdata_hold: rdata=%h ack=%b, want 5a 0000", bus.rdata, bus.ack);
    end
  endtask

  task automatic test_read_before_write();
    int n;
    do_reset();
    post(1, 1'b1, 8'h20, 8'h33);
    wait_ack(1, 10, n);
    tick();
    post(1, 1'b1, 8'h20, 8'h44);
    wait_ack(1, 10, n);
    tests++;
    if (n !== 2 || bus.rdata !== 8'h33) begin
      fails++;
      $display("FAIL rbw_old: latency=%0d rdata=%h, want 2 33", n, bus.rdata);
    end
    tick();
    post(1, 1'b0, 8'h20, 8'h00);
    wait_ack(1, 10, n);
    tests++;
    if (n !== 2 || bus.rdata !== 8'h44) begin
      fails++;
      $display("FAIL rbw_new: latency=%0d rdata=%h, want 2 44", n, bus.rdata);
    end
  endtask

  task automatic test_all_four();
    int ack_at [N];
    int bad_busy;
    do_reset();
    for (int i = 0; i < N; i++) begin
      ack_at[i] = -1;
      post(i, 1'b0, AW'(8'h40 + i), 8'h00);
    end
    bad_busy = 0;
    for (int t = 1; t <= 13; t++) begin
      tick();
      for (int i = 0; i < N; i++) if (bus.ack[i] === 1'b1) ack_at[i] = t;
      if (busy !== e_busy || bus.ack !== e_ack) bad_busy++;
    end
    for (int i = 0; i < N; i++) begin
      tests++;
      if (ack_at[i] !== 2 + 3 * i) begin
        fails++;
        $display("FAIL all4_order: req%0d acked at cycle %0d, want %0d", i, ack_at[i], 2 + 3 * i);
      end
    end
    tests++;
    if (bad_busy != 0) begin
      fails++;
      $display("FAIL all4_busy: %0d cycles with busy/ack off model, want 0", bad_busy);
    end
  endtask

  task automatic test_fairness();
    int seq[$];
    int w2;
    do_reset();
    p_hold[0] = 1'b1;
    post(0, 1'b0, 8'h01, 8'h00);
    tick();
    post(2, 1'b0, 8'h02, 8'h00);
    w2 = -1;
    for (int t = 2; t <= 10; t++) begin
      tick();
      for (int i = 0; i < N; i++) if (bus.ack[i] === 1'b1) seq.push_back(i);
      if (bus.ack[2] === 1'b1) w2 = t - 1;
    end
    tests++;
    if (seq.size() != 3 || seq[0] != 0 || seq[1] != 2 || seq[2] != 0) begin
      fails++;
      $display("FAIL fair_seq: %0d acks, first=%0d,%0d,%0d, want 3 acks 0,2,0", seq.size(),
               (seq.size() > 0) ? seq[0] : -1, (seq.size() > 1) ? seq[1] : -1,
               (seq.size() > 2) ? seq[2] : -1);
    end
    tests++;
    if (w2 < 0 || w2 > 6) begin
      fails++;
      $display("FAIL fair_wait: req2 waited %0d cycles, want 1..6", w2);
    end
  endtask

  task automatic test_reset_mid_access();
    int n, spurious;
    do_reset();
    post(0, 1'b1, 8'h05, 8'h77);
    tick();
    tests++;
    if (dbg_state !== ACCESS || ram_wren !== 1'b1) begin
      fails++;
      $display("FAIL rst_pre: state=%0d wren=%b, want %0d 1", dbg_state, ram_wren, ACCESS);
    end
    reset_n  = 1'b0;
    p_req[0] = 1'b0;
    tick();
    reset_n = 1'b1;
    tests++;
    if (dbg_state !== IDLE || bus.ack !== '0 || busy !== 1'b0 || ram_wren !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: state=%0d ack=%b busy=%b wren=%b, want %0d 0000 0 0",
               dbg_state, bus.ack, busy, ram_wren, IDLE);
    end
    spurious = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (bus.ack !== '0 || busy !== 1'b0) spurious++;
    end
    tests++;
    if (spurious != 0 || mem[8'h05] !== 8'h77) begin
      fails++;
      $display("FAIL rst_ram: spurious=%0d ram[05]=%h, want 0 77", spurious, mem[8'h05]);
    end
    post(0, 1'b0, 8'h05, 8'h00);
    wait_ack(0, 10, n);
    tests++;
    if (n !== 2 || bus.rdata !== 8'h77) begin
      fails++;
      $display("FAIL rst_readback: latency=%0d rdata=%h, want 2 77", n, bus.rdata);
    end
  endtask

  task automatic test_idle();
    do_reset();
    for (int t = 0; t < 20; t++) begin
      tick();
      tests++;
      if (ram_wren !== 1'b0 || busy !== 1'b0 || bus.ack !== '0) begin
        fails++;
        $display("FAIL idle: cycle %0d wren=%b busy=%b ack=%b, want 0 0 0000",
                 t, ram_wren, busy, bus.ack);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] just;
    int pending;
    do_reset();
    just = '0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++)
        if (!p_req[i] && !just[i] && $urandom_range(0, 3) == 0)
          post(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom_range(0, 255)));
      tick();
      just = e_ack;
      tests++;
      if (bus.ack !== e_ack || busy !== e_busy || ram_wren !== e_wren) begin
        fails++;
        $display("FAIL rnd_ctl: t=%0d ack=%b busy=%b wren=%b, want %b %b %b",
                 t, bus.ack, busy, ram_wren, e_ack, e_busy, e_wren);
      end
      tests++;
      if (bus.rdata !== e_rdata || grant_id !== e_grant || ram_address !== e_addr) begin
        fails++;
        $display("FAIL rnd_data: t=%0d rdata=%h grant=%0d addr=%h, want %h %0d %h",
                 t, bus.rdata, grant_id, ram_address, e_rdata, e_grant, e_addr);
      end
      if (acked >= 0) begin
        tests++;
        if (ack_wait > 3 * N) begin
          fails++;
          $display("FAIL rnd_wait: req%0d waited %0d cycles, want <= %0d", acked, ack_wait, 3 * N);
        end
      end
    end
    for (int t = 0; t < 60; t++) begin
      pending = 0;
      for (int i = 0; i < N; i++) if (p_req[i]) pending++;
      if (pending == 0) break;
      tick();
    end
    tests++;
    if (pending != 0) begin
      fails++;
      $display("FAIL rnd_drain: %0d requests still pending, want 0", pending);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < N; i++) begin
      p_req[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
      p_hold[i] = 1'b0; p_wait[i] = 0;
    end
    g = 2; last_g = N - 1; w_we = 1'b0; w_rd = '0;
    test_reset();
    test_write_read();
    test_read_before_write();
    test_all_four();
    test_fairness();
    test_reset_mid_access();
    test_idle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
